legv8_instr_encoder: RTL and testbench

- Counterpart to the control-unit opcode decode: takes a symbolic instruction command (op select, register fields, immediate) and encodes it into a 32-bit LEGv8 machine word.
- Writes each encoded word into instruction memory at an auto-incrementing word address.
- Used by the test/boot path to load programs into instruction memory before the datapath runs.
- Checks immediate ranges per format and returns a per-command response with an error code.

---
 rtl/legv8_instr_encoder_if.sv | 33 +++
 rtl/legv8_instr_encoder.sv | 171 +++++++++++++++++
 tb/tb_legv8_instr_encoder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/legv8_instr_encoder_if.sv
// Command, instruction-memory write and response bundle for legv8_instr_encoder.
// master = loader/test side that issues commands; slave = the encoder.
interface legv8_instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              clr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rn;
  logic [4:0]        cmd_rm;
  logic [25:0]       cmd_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [1:0]        rsp_err;
  logic [ADDR_W:0]   wr_count;
  logic              full;

  modport master (
    output clr, cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, mem_ack, mem_rdata,
    input  cmd_ready, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_err, wr_count, full
  );

  modport slave (
    input  clr, cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, mem_ack, mem_rdata,
    output cmd_ready, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_err, wr_count, full
  );
endinterface

// File: rtl/legv8_instr_encoder.sv
// Encodes symbolic LEGv8 commands into 32-bit words and writes them to instruction memory at an auto-incrementing address;
// one command in flight, mem_we held until mem_ack; ENC_READBACK_EN adds a VERIFY readback cycle.
module legv8_instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  legv8_instr_encoder_if.slave  bus
);

`ifdef ENC_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_ENC, S_WRITE, S_VERIFY, S_RESP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE, S_RESP} state_t;
`endif

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [25:0]       imm_q, imm_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        err_q, err_d;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              enc_imm_ok;
  logic [1:0]        enc_err;

  // Signed ranges are checked by requiring the bits above the field to be a pure sign extension.
  always_comb begin
    enc_word   = '0;
    enc_legal  = 1'b1;
    enc_imm_ok = 1'b1;
    case (op_q)
      4'd0:  enc_word = {11'b10001011000, rm_q, 6'b0, rn_q, rd_q};
      4'd1:  enc_word = {11'b11001011000, rm_q, 6'b0, rn_q, rd_q};
      4'd2:  enc_word = {11'b10001010000, rm_q, 6'b0, rn_q, rd_q};
      4'd3:  enc_word = {11'b10101010000, rm_q, 6'b0, rn_q, rd_q};
      4'd4, 4'd5: begin
        enc_word   = {(op_q == 4'd4) ? 11'b11111000010 : 11'b11111000000,
                      imm_q[8:0], 2'b00, rn_q, rd_q};
        enc_imm_ok = (&imm_q[25:8]) || (~|imm_q[25:8]);
      end
      4'd6:  enc_word = {6'b000101, imm_q};
      4'd7, 4'd8: begin
        enc_word   = {(op_q == 4'd7) ? 8'b10110100 : 8'b10110101, imm_q[18:0], rd_q};
        enc_imm_ok = (&imm_q[25:18]) || (~|imm_q[25:18]);
      end
      4'd9:  enc_word = {10'b1001000100, imm_q[11:0], rn_q, rd_q};
      4'd10: enc_word = {10'b1101000100, imm_q[11:0], rn_q, rd_q};
      4'd11: enc_word = {10'b1001001000, imm_q[11:0], rn_q, rd_q};
      4'd12: enc_word = {10'b1011001000, imm_q[11:0], rn_q, rd_q};
      default: enc_legal = 1'b0;
    endcase
    if (op_q >= 4'd9 && op_q <= 4'd12) begin
      enc_imm_ok = ~|imm_q[25:12];
    end
    if (!enc_legal)       enc_err = 2'd1;
    else if (full_q)      enc_err = 2'd3;
    else if (!enc_imm_ok) enc_err = 2'd2;
    else                  enc_err = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    imm_d   = imm_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr) begin
          ptr_d  = BASE;
          cnt_d  = '0;
          full_d = 1'b0;
        end else if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          rd_d    = bus.cmd_rd;
          rn_d    = bus.cmd_rn;
          rm_d    = bus.cmd_rm;
          imm_d   = bus.cmd_imm;
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        word_d  = enc_word;
        err_d   = enc_err;
        state_d = (enc_err != 2'd0) ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          // The pointer wraps to 0 naturally when the last word is written.
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (&ptr_q) full_d = 1'b1;
`ifdef ENC_READBACK_EN
          state_d = S_VERIFY;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef ENC_READBACK_EN
      S_VERIFY: begin
        if (bus.mem_rdata != word_q) err_d = 2'd3;
        state_d = S_RESP;
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= '0;
      word_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      imm_q   <= imm_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE) && !bus.clr && !rst;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_wdata = word_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = err_q;
  assign bus.wr_count  = cnt_q;
  assign bus.full      = full_q;

`ifdef ENC_READBACK_EN
  // The pointer has already advanced in VERIFY, so step back to the word just written.
  assign bus.mem_addr = (state_q == S_VERIFY) ? ptr_q - 1'b1 : ptr_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;
  assign bus.mem_addr = ptr_q;
`endif

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed, table-driven bench for legv8_instr_encoder with a 4-word memory (ADDR_W=2) so the full/wrap path is reachable.
module tb_legv8_instr_encoder;
  localparam int AW = 2;
`ifdef ENC_READBACK_EN
  localparam int LAT_OK = 4;
`else
  localparam int LAT_OK = 3;
`endif

  typedef struct {
    bit          clr_first;
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [25:0] imm;
    logic [31:0] word;
    logic [1:0]  err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  legv8_instr_encoder_if #(.ADDR_W(AW)) bus ();
  legv8_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passes = 0;
  int nwr = 0;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_word;
  logic [31:0]   tb_mem [4];
  logic          corrupt = 1'b0;
  int mptr = 0, mcnt = 0;
  bit mfull = 1'b0;

  assign bus.mem_rdata = tb_mem[bus.mem_addr] ^ {31'b0, corrupt};

  always @(posedge clk) begin
    if (!rst && bus.mem_we && bus.mem_ack) begin
      nwr++;
      wr_addr = bus.mem_addr;
      wr_word = bus.mem_wdata;
      tb_mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(bit c, int op, int rd, int rn, int rm, int imm, logic [31:0] w, int e);
    vec_t v;
    v.clr_first = c;
    v.op = 4'(op); v.rd = 5'(rd); v.rn = 5'(rn); v.rm = 5'(rm);
    v.imm = 26'(imm); v.word = w; v.err = 2'(e);
    return v;
  endfunction

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    #1 chk("clr_ready_low", bus.cmd_ready, 1'b0);
    @(negedge clk);
    bus.clr = 1'b0;
    #1;
    chk("clr_wr_count", bus.wr_count, 0);
    chk("clr_full", bus.full, 1'b0);
    mptr = 0; mcnt = 0; mfull = 1'b0;
  endtask

  task automatic send(input vec_t v);
    @(negedge clk);
    bus.cmd_op = v.op; bus.cmd_rd = v.rd; bus.cmd_rn = v.rn;
    bus.cmd_rm = v.rm; bus.cmd_imm = v.imm; bus.cmd_valid = 1'b1;
    #1 chk("cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // lat counts falling edges after the accepting rising edge.
  task automatic wait_rsp(output bit seen, output int lat);
    seen = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!seen && lat < 30) begin
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!seen) chk("rsp_timeout", 1'b0, 1'b1);
  endtask

  task automatic finish_cmd(input string tag, input vec_t v, input logic [1:0] exp_err,
                            input bit exp_wr, input int n0, input int exp_lat, input bit seen, input int lat);
    int exp_addr;
    exp_addr = mptr;
    if (seen) begin
      chk({tag, "_err"}, bus.rsp_err, exp_err);
      if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    end
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, bus.rsp_valid, 1'b0);
    chk({tag, "_nwrites"}, nwr - n0, exp_wr ? 1 : 0);
    if (exp_wr) begin
      chk({tag, "_addr"}, wr_addr, exp_addr);
      chk({tag, "_word"}, wr_word, v.word);
      if (mptr == 3) mfull = 1'b1;
      mptr = (mptr + 1) % 4;
      mcnt++;
    end
    chk({tag, "_wr_count"}, bus.wr_count, mcnt);
    chk({tag, "_full"}, bus.full, mfull);
  endtask

  task automatic run_cmd(input string tag, input vec_t v, input logic [1:0] exp_err, input bit exp_wr, input int exp_lat);
    int n0, lat;
    bit seen;
    n0 = nwr;
    send(v);
    wait_rsp(seen, lat);
    finish_cmd(tag, v, exp_err, exp_wr, n0, exp_lat, seen, lat);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int n0, lat, cyc;
    bit seen;
    for (int i = 0; i < 4; i++) tb_mem[i] = '0;

    tbl.push_back(mk(0, 0,  1,  2,  3, 0,        32'h8B030041, 0));
    tbl.push_back(mk(0, 9,  9, 10,  0, 4095,     32'h913FFD49, 0));
    tbl.push_back(mk(0, 9,  9, 10,  0, 4096,     32'h0,        2));
    tbl.push_back(mk(0, 4,  1,  2,  0, -256,     32'hF8500041, 0));
    tbl.push_back(mk(0, 7,  5,  0,  0, -1,       32'hB4FFFFE5, 0));
    tbl.push_back(mk(0, 14, 0,  0,  0, 0,        32'h0,        1));
    tbl.push_back(mk(0, 1,  31, 0, 31, 0,        32'h0,        3));
    tbl.push_back(mk(1, 1,  31, 0, 31, 0,        32'hCB1F001F, 0));
    tbl.push_back(mk(0, 2,  4,  5,  6, 0,        32'h8A0600A4, 0));
    tbl.push_back(mk(0, 3,  7,  8,  9, 0,        32'hAA090107, 0));
    tbl.push_back(mk(0, 4,  1,  2,  0, 256,      32'h0,        2));
    tbl.push_back(mk(0, 5,  3,  4,  0, 255,      32'hF80FF083, 0));
    tbl.push_back(mk(0, 7,  0,  0,  0, 1 << 18,  32'h0,        3));
    tbl.push_back(mk(1, 6,  0,  0,  0, -1,       32'h17FFFFFF, 0));
    tbl.push_back(mk(0, 8,  2,  0,  0, (1 << 18) - 1, 32'hB57FFFE2, 0));
    tbl.push_back(mk(0, 7,  0,  0,  0, 1 << 18,  32'h0,        2));
    tbl.push_back(mk(0, 7,  0,  0,  0, -(1 << 18), 32'hB4800000, 0));
    tbl.push_back(mk(0, 9,  1,  1,  0, -1,       32'h0,        2));
    tbl.push_back(mk(0, 15, 0,  0,  0, 0,        32'h0,        1));
    tbl.push_back(mk(0, 10, 1,  1,  0, 0,        32'hD1000021, 0));
    tbl.push_back(mk(1, 11, 2,  3,  0, 12'hABC,  32'h922AF062, 0));
    tbl.push_back(mk(0, 12, 0, 31,  0, 1,        32'hB20007E0, 0));
    tbl.push_back(mk(0, 4,  1,  2,  0, -257,     32'h0,        2));
    tbl.push_back(mk(0, 13, 0,  0,  0, 0,        32'h0,        1));

    rst = 1'b1; bus.clr = 1'b0; bus.cmd_valid = 1'b0; bus.mem_ack = 1'b1;
    bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rn = '0; bus.cmd_rm = '0; bus.cmd_imm = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_wr_count", bus.wr_count, 0);
    chk("rst_full", bus.full, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].clr_first) do_clr();
      run_cmd($sformatf("v%0d", i), tbl[i], tbl[i].err, tbl[i].err == 2'd0,
              (tbl[i].err == 2'd0) ? LAT_OK : 2);
    end

    // Stalled ack: the write must hold steady until acknowledged.
    v = mk(0, 0, 1, 2, 3, 0, 32'h8B030041, 0);
    bus.mem_ack = 1'b0;
    n0 = nwr;
    send(v);
    cyc = 0;
    while (!bus.mem_we && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_we_seen", bus.mem_we, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_we", k), bus.mem_we, 1'b1);
      chk($sformatf("stall%0d_addr", k), bus.mem_addr, mptr);
      chk($sformatf("stall%0d_wdata", k), bus.mem_wdata, 32'h8B030041);
      chk($sformatf("stall%0d_rsp", k), bus.rsp_valid, 1'b0);
      @(negedge clk);
    end
    chk("stall_no_write_yet", nwr - n0, 0);
    bus.mem_ack = 1'b1;
    wait_rsp(seen, lat);
    finish_cmd("stall", v, 2'd0, 1'b1, n0, 0, seen, lat);

`ifdef ENC_READBACK_EN
    do_clr();
    corrupt = 1'b1;
    run_cmd("readback", v, 2'd3, 1'b1, LAT_OK);
    corrupt = 1'b0;
`endif

    // Reset in the middle of a stalled write abandons it.
    bus.mem_ack = 1'b0;
    n0 = nwr;
    send(v);
    cyc = 0;
    while (!bus.mem_we && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstw_we_seen", bus.mem_we, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstw_we_dropped", bus.mem_we, 1'b0);
    chk("rstw_wr_count", bus.wr_count, 0);
    chk("rstw_mem_addr", bus.mem_addr, 0);
    chk("rstw_rsp", bus.rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    #1 chk("rstw_idle_ready", bus.cmd_ready, 1'b1);
    chk("rstw_no_write", nwr - n0, 0);
    mptr = 0; mcnt = 0; mfull = 1'b0;
    run_cmd("post_rst", v, 2'd0, 1'b1, LAT_OK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
